// File: rtl/mux2_1.sv
// Write-back select: picks memory read data or ALU result.
// Also offers a registered copy of the selection with load enable.
module mux2_1 #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] entradaA,
  input  logic [WIDTH-1:0] entradaB,
  input  logic             controle,
  input  logic             en,
  output logic [WIDTH-1:0] saida,
  output logic [WIDTH-1:0] saida_q,
  output logic             controle_q
);

  logic [WIDTH-1:0] saida_d;
  logic             sel_d;
  logic [WIDTH-1:0] saida_r;
  logic             sel_r;

  // Only a definite 1 picks the ALU result; 0/X/Z fall back to memory data
  always_comb begin
    sel_d   = 1'b0;
    saida_d = entradaA;
    if (controle == 1'b1) begin
      sel_d   = 1'b1;
      saida_d = entradaB;
    end
  end

  assign saida = saida_d;

  // Registered copy; async clear wins over a simultaneous load
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      saida_r <= '0;
      sel_r   <= 1'b0;
    end else if (en) begin
      saida_r <= saida_d;
      sel_r   <= sel_d;
    end
  end

  assign saida_q    = saida_r;
  assign controle_q = sel_r;

endmodule

// File: tb/tb_mux2_1.sv
// Bench for mux2_1: directed and random checks against
// a behavioural select model with a registered shadow copy.
module tb_mux2_1;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [31:0] entradaA;
  logic [31:0] entradaB;
  logic        controle;
  logic        en;
  logic [31:0] saida;
  logic [31:0] saida_q;
  logic        controle_q;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q;
  logic        exp_cq;
  logic [31:0] held;

  mux2_1 #(.WIDTH(32)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .entradaA   (entradaA),
    .entradaB   (entradaB),
    .controle   (controle),
    .en         (en),
    .saida      (saida),
    .saida_q    (saida_q),
    .controle_q (controle_q)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] pick(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    if (s === 1'b1) return b;
    return a;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n  = 1'b0;
    en       = 1'b0;
    controle = 1'b0;
    entradaA = '0;
    entradaB = '0;
    exp_q    = '0;
    exp_cq   = 1'b0;
    #1;
    chk("rst_saida_q", saida_q, 32'h0);
    chk("rst_controle_q", {31'b0, controle_q}, 32'h0);

    controle = 1'b0;
    entradaA = 32'h8000_0001;
    entradaB = 32'hFFFF_FFFF;
    #1;
    chk("sel0_directed", saida, 32'h8000_0001);

    controle = 1'b1;
    entradaB = 32'hDEAD_BEEF;
    #1;
    chk("sel1_directed", saida, 32'hDEAD_BEEF);

    for (int i = 0; i < 20; i++) begin
      controle = (i >= 10);
      entradaA = $urandom | 32'h8000_0000;
      entradaB = $urandom | 32'h8000_0000;
      #1;
      chk(controle ? "rand_sel1" : "rand_sel0", saida,
          pick(entradaA, entradaB, controle));
    end

    controle = 1'bx;
    entradaA = 32'h1234_5678;
    entradaB = 32'h8765_4321;
    #1;
    chk("selx", saida, 32'h1234_5678);
    checks++;
    assert ((^saida) !== 1'bx) else begin
      failures++;
      $error("FAIL selx_noX observed=%h expected=%h", saida, 32'h1234_5678);
    end

    // Release reset mid-cycle, then load CAFE_0001 through port B
    @(negedge Clock);
    Reset_n  = 1'b1;
    en       = 1'b1;
    controle = 1'b1;
    entradaB = 32'hCAFE_0001;
    exp_q    = pick(entradaA, entradaB, controle);
    exp_cq   = 1'b1;
    @(posedge Clock);
    #1;
    chk("load_saida_q", saida_q, exp_q);
    chk("load_controle_q", {31'b0, controle_q}, {31'b0, exp_cq});

    @(negedge Clock);
    en       = 1'b0;
    controle = 1'b0;
    entradaA = 32'h0BAD_F00D;
    entradaB = 32'h1111_2222;
    #1;
    chk("hold_saida_follows", saida, 32'h0BAD_F00D);
    chk("hold_saida_q_pre", saida_q, 32'hCAFE_0001);
    @(posedge Clock);
    #1;
    chk("hold_saida_q", saida_q, 32'hCAFE_0001);
    chk("hold_controle_q", {31'b0, controle_q}, 32'h1);

    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      en       = $urandom_range(0, 1);
      controle = $urandom_range(0, 1);
      entradaA = $urandom;
      entradaB = $urandom;
      if (en) begin
        exp_q  = pick(entradaA, entradaB, controle);
        exp_cq = (controle === 1'b1);
      end
      @(posedge Clock);
      #1;
      chk("rand_reg_q", saida_q, exp_q);
      chk("rand_reg_cq", {31'b0, controle_q}, {31'b0, exp_cq});
    end

    // Make sure the register holds a nonzero value before reset
    @(negedge Clock);
    en       = 1'b1;
    controle = 1'b1;
    entradaB = 32'hA5A5_0F0F;
    @(posedge Clock);
    #1;
    chk("preload_q", saida_q, 32'hA5A5_0F0F);

    @(negedge Clock);
    #2;
    held    = saida;
    Reset_n = 1'b0;
    #1;
    chk("async_rst_q", saida_q, 32'h0);
    chk("async_rst_cq", {31'b0, controle_q}, 32'h0);
    chk("async_rst_saida", saida, held);

    entradaB = 32'h7777_8888;
    #1;
    chk("rst_saida_live", saida, 32'h7777_8888);
    @(posedge Clock);
    #1;
    chk("rst_beats_en", saida_q, 32'h0);

    @(negedge Clock);
    Reset_n = 1'b1;
    exp_q   = pick(entradaA, entradaB, controle);
    @(posedge Clock);
    #1;
    chk("post_rst_load", saida_q, exp_q);
    chk("post_rst_cq", {31'b0, controle_q}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
